// File: rtl/data_memory_arbiter_pkg.sv
// Shared constants and response-state encodings for the data memory arbiter.
// Imported by the arbiter top and its starvation counter.
package data_memory_arbiter_pkg;

    localparam int ADDR_W_DEF       = 10;
    localparam int XLEN_DEF         = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STARVE_CNT_W     = 4;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_CORE = 2'd1,
        RSP_DBG  = 2'd2
    } rsp_state_t;

endpackage

// File: rtl/data_memory_arbiter_saturating_counter.sv
// Starvation counter for the debug port: clear has priority over increment.
// Saturation is enforced by the caller gating inc at the limit.
module saturating_counter
    import data_memory_arbiter_pkg::*;
#(
    parameter int WIDTH = STARVE_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_value <= '0;
        end else if (clear) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= r_value + WIDTH'(1);
        end
    end

    assign value = r_value;

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter (core MEM stage + debug/loader) in front of a synchronous
// data memory; core has priority until the debug port has waited STARVE_LIMIT.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int XLEN         = XLEN_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [XLEN-1:0]   core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [XLEN-1:0]   core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [XLEN-1:0]   dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [XLEN-1:0]   dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              mem_wren,
    input  logic [XLEN-1:0]   mem_q,
    output logic              stall
);

    localparam logic [STARVE_CNT_W-1:0] LP_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] w_starve_cnt;
    logic                    w_starved;
    logic                    w_core_gnt;
    logic                    w_dbg_gnt;
    logic                    w_cnt_inc;
    logic                    w_cnt_clr;
    rsp_state_t              r_state;
    rsp_state_t              w_state_nxt;

    assign w_starved  = (w_starve_cnt == LP_LIMIT);
    assign w_dbg_gnt  = dbg_req && (!core_req || w_starved);
    assign w_core_gnt = core_req && !w_dbg_gnt;

    assign core_gnt = w_core_gnt;
    assign dbg_gnt  = w_dbg_gnt;
    assign stall    = core_req && !w_core_gnt;

    assign w_cnt_inc = dbg_req && !w_dbg_gnt && !w_starved;
    assign w_cnt_clr = w_dbg_gnt || !dbg_req;

    saturating_counter #(
        .WIDTH (STARVE_CNT_W)
    ) u_starve_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_cnt_inc),
        .clear (w_cnt_clr),
        .value (w_starve_cnt)
    );

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        unique case (1'b1)
            w_core_gnt: begin
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
                mem_wren  = core_we;
            end
            w_dbg_gnt: begin
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                mem_wren  = dbg_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= RSP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = RSP_IDLE;
        core_rvalid = 1'b0;
        core_rdata  = '0;
        dbg_rvalid  = 1'b0;
        dbg_rdata   = '0;
        if (w_core_gnt && !core_we) begin
            w_state_nxt = RSP_CORE;
        end else if (w_dbg_gnt && !dbg_we) begin
            w_state_nxt = RSP_DBG;
        end
        unique case (r_state)
            RSP_CORE: begin
                core_rvalid = 1'b1;
                core_rdata  = mem_q;
            end
            RSP_DBG: begin
                dbg_rvalid = 1'b1;
                dbg_rdata  = mem_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, data memory word-address width.
REQ-002 Parameter XLEN, default 32, data width, taken from riscv.h.
REQ-003 Parameter STARVE_LIMIT, default 4, max cycles the debug port waits while the core holds the memory; legal range 1..15.
REQ-004 clock  input  1  single clock; all state is on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 core_req  input  1  core MEM-stage access request.
REQ-007 core_we  input  1  core request is a write.
REQ-008 core_addr  input  ADDR_W  core word address.
REQ-009 core_wdata  input  XLEN  core write data.
REQ-010 core_gnt  output  1  core request is accepted this cycle.
REQ-011 core_rvalid  output  1  core read data is valid this cycle.
REQ-012 core_rdata  output  XLEN  core read data.
REQ-013 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: debug/loader port; same directions and widths as REQ-006..REQ-012.
REQ-014 mem_addr  output  ADDR_W  address to the synchronous data memory (input-registered).
REQ-015 mem_wdata  output  XLEN  write data to the memory.
REQ-016 mem_wren  output  1  memory write enable.
REQ-017 mem_q  input  XLEN  memory read data, valid one cycle after the address is presented.
REQ-018 stall  output  1  pipeline stall request to the core, equal to core_req && !core_gnt.

Function
REQ-019 The grant SHALL be combinational: dbg_gnt = dbg_req && (!core_req || starve_cnt == STARVE_LIMIT); core_gnt = core_req && !dbg_gnt.
REQ-020 At most one grant SHALL be high in any cycle.
REQ-021 starve_cnt SHALL increment when dbg_req && !dbg_gnt, saturate at STARVE_LIMIT, and clear to 0 on dbg_gnt or !dbg_req.
REQ-022 mem_addr, mem_wdata and mem_wren SHALL mirror the granted port's addr, wdata and (req && we); with no grant they SHALL be 0, 0 and 0.
REQ-023 The response FSM SHALL have the states RSP_IDLE, RSP_CORE and RSP_DBG; next state is RSP_CORE on a granted core read, RSP_DBG on a granted debug read, otherwise RSP_IDLE.
REQ-024 In RSP_CORE: core_rvalid=1, core_rdata=mem_q. In RSP_DBG: dbg_rvalid=1, dbg_rdata=mem_q. The non-selected rdata SHALL be 0.
REQ-025 Read latency SHALL be exactly 1 cycle from grant to rvalid; back-to-back reads, including reads alternating between ports, SHALL sustain 1 access per cycle.
REQ-026 Writes SHALL complete in the cycle of grant and SHALL never raise rvalid.
REQ-027 A request that is not granted SHALL keep its inputs stable and be held by the requester; the arbiter SHALL NOT buffer requests.
REQ-028 With simultaneous requests and starve_cnt < STARVE_LIMIT, the core SHALL win; the debug port SHALL be granted no later than STARVE_LIMIT+1 cycles after it first asserts dbg_req.

Reset
REQ-029 While reset is high: starve_cnt=0, FSM=RSP_IDLE, both rvalid=0, and both rdata=0. Grants, stall and the mem outputs SHALL follow REQ-019, REQ-022 and REQ-018.
REQ-030 Asserting reset mid-read SHALL drop the pending rvalid asynchronously; it SHALL NOT be delivered after reset is released.

Structure
REQ-031 XLEN SHALL come from riscv.h. The response-state encodings and the STARVE_LIMIT default SHALL live in a shared header, arbiter_codes.h.
REQ-032 The starvation counter SHALL be a separate sub-module, saturating_counter, with parameter WIDTH and ports clock, reset, inc, clear and value. The rest of the block SHALL be flat.

Verification
REQ-033 core read addr 0x010 alone, memory word 0x010 = 0xDEADBEEF -> core_gnt=1 and stall=0 in cycle 0; core_rvalid=1 with core_rdata=0xDEADBEEF in cycle 1; dbg_rvalid=0.
REQ-034 core_req and dbg_req held continuously, STARVE_LIMIT=4 -> core granted in cycles 0..3, dbg granted in cycle 4, stall=1 in cycle 4, starve_cnt=0 in cycle 5.
REQ-035 dbg write addr 0x3FF, data 0x12345678, with no core request -> mem_wren=1, mem_addr=0x3FF, mem_wdata=0x12345678 in the same cycle; no rvalid next cycle; a core read of 0x3FF then returns 0x12345678.
REQ-036 Alternating reads core@0x001, dbg@0x002, core@0x003 in consecutive cycles -> rvalid toggles core/dbg/core in cycles 1..3 with the matching data and no bubble.
REQ-037 Reset asserted in the cycle after a granted core read -> core_rvalid=0 immediately; no rvalid pulses after reset is released; starve_cnt=0.
